// File: rtl/esi_mmio_pkg.sv
// Shared types and AXI-lite response codes for the ESI cosim MMIO register bank.
package esi_mmio_pkg;

  typedef logic [1:0]  axil_resp_t;
  typedef logic [31:0] mmio_addr_t;
  typedef logic [63:0] mmio_data_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;
  localparam axil_resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/esi_mmio_addr_decode.sv
// Combinational byte-address decode into a register index and an AXI-lite response code.
module esi_mmio_addr_decode
  import esi_mmio_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter mmio_addr_t  BASE_ADDR = 32'h0000_0000,
  localparam int unsigned IdxW     = $clog2(NUM_REGS)
) (
  input  mmio_addr_t        addr_i,
  input  logic              is_write_i,
  output logic [IdxW-1:0]   idx_o,
  output axil_resp_t        resp_o
);

  localparam mmio_addr_t Span = mmio_addr_t'(NUM_REGS * 8);

  mmio_addr_t off;
  assign off = addr_i - BASE_ADDR;

  always_comb begin
    idx_o  = IdxW'(off >> 3);
    resp_o = RESP_OKAY;
    // Range check first so a wrapped subtraction below BASE_ADDR is never treated as in-range.
    if (addr_i < BASE_ADDR || off >= Span) begin
      resp_o = RESP_DECERR;
    end else if (off[2:0] != 3'b000) begin
      resp_o = RESP_SLVERR;
    end else if (is_write_i && idx_o == '0) begin
      resp_o = RESP_SLVERR;
    end
  end

endmodule

// File: rtl/esi_mmio_axil_regbank.sv
// AXI-lite slave register bank behind the cosim MMIO driver; register 0 is a read-only magic word.
module esi_mmio_axil_regbank
  import esi_mmio_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter mmio_addr_t  BASE_ADDR = 32'h0000_0000,
  parameter mmio_data_t  MAGIC     = 64'h207D_98E5_E510_0E51
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [31:0]              araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [63:0]              rdata,
  output logic [1:0]               rresp,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [63:0]              wdata,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  output logic [NUM_REGS*64-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  typedef enum logic {RIdle, RResp}    rd_state_e;
  typedef enum logic {WCollect, WResp} wr_state_e;

  rd_state_e  rd_state_q, rd_state_d;
  wr_state_e  wr_state_q, wr_state_d;
  mmio_data_t rdata_q, rdata_d;
  axil_resp_t rresp_q, rresp_d;
  axil_resp_t bresp_q, bresp_d;
  logic       aw_held_q, aw_held_d, w_held_q, w_held_d;
  mmio_addr_t awaddr_q, awaddr_d;
  mmio_data_t wdata_q, wdata_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  mmio_data_t regs_q [1:NUM_REGS-1];
  mmio_data_t regs_d [1:NUM_REGS-1];
  mmio_data_t reg_view [NUM_REGS];

  logic [IdxW-1:0] rd_idx, wr_idx;
  axil_resp_t      rd_resp, wr_resp;
  mmio_addr_t      wr_addr;
  mmio_data_t      wr_data;
  logic            aw_fire, w_fire, commit;

  esi_mmio_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_rd_decode (
    .addr_i     (araddr),
    .is_write_i (1'b0),
    .idx_o      (rd_idx),
    .resp_o     (rd_resp)
  );

  esi_mmio_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_wr_decode (
    .addr_i     (wr_addr),
    .is_write_i (1'b1),
    .idx_o      (wr_idx),
    .resp_o     (wr_resp)
  );

  always_comb begin
    reg_view[0] = MAGIC;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      reg_view[i] = regs_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*64 +: 64] = reg_view[g];
  end

  // Read channel
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    arready    = (rd_state_q == RIdle);
    rvalid     = (rd_state_q == RResp);
    unique case (rd_state_q)
      RIdle: begin
        if (arvalid) begin
          // Sampled from the registered state, so a same-cycle write commit is not yet visible.
          rdata_d    = (rd_resp == RESP_OKAY) ? reg_view[rd_idx] : '0;
          rresp_d    = rd_resp;
          rd_state_d = RResp;
        end
      end
      RResp: begin
        if (rready) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  // Write channel
  assign awready = (wr_state_q == WCollect) && !aw_held_q;
  assign wready  = (wr_state_q == WCollect) && !w_held_q;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign wr_addr = aw_held_q ? awaddr_q : awaddr;
  assign wr_data = w_held_q ? wdata_q : wdata;
  assign commit  = (wr_state_q == WCollect) && (aw_held_q || aw_fire) && (w_held_q || w_fire);

  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    aw_held_d  = aw_held_q || aw_fire;
    w_held_d   = w_held_q || w_fire;
    awaddr_d   = aw_fire ? awaddr : awaddr_q;
    wdata_d    = w_fire ? wdata : wdata_q;
    pulse_d    = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    unique case (wr_state_q)
      WCollect: begin
        if (commit) begin
          bresp_d    = wr_resp;
          wr_state_d = WResp;
          if (wr_resp == RESP_OKAY) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
              if (wr_idx == IdxW'(i)) begin
                regs_d[i]  = wr_data;
                pulse_d[i] = 1'b1;
              end
            end
          end
        end
      end
      WResp: begin
        if (bready) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WCollect;
        end
      end
      default: wr_state_d = WCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RIdle;
      wr_state_q <= WCollect;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      bresp_q    <= RESP_OKAY;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      pulse_q    <= '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      bresp_q    <= bresp_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      pulse_q    <= pulse_d;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign bvalid       = (wr_state_q == WResp);
  assign bresp        = bresp_q;
  assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_esi_mmio_axil_regbank.sv
// Directed plus randomized bench for the MMIO register bank against an array-based model.
module tb_esi_mmio_axil_regbank;

  localparam int unsigned NUM_REGS  = 16;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam logic [63:0] MAGIC     = 64'h207D_98E5_E510_0E51;

  logic clk = 1'b0;
  logic rst;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] araddr, awaddr;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic [NUM_REGS*64-1:0] regs_o;
  logic [NUM_REGS-1:0]    reg_wr_pulse;

  int total = 0;
  int bad   = 0;
  logic [63:0] model [NUM_REGS];

  always #5 clk = ~clk;

  esi_mmio_axil_regbank #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .MAGIC     (MAGIC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arvalid      (arvalid),
    .arready      (arready),
    .araddr       (araddr),
    .rvalid       (rvalid),
    .rready       (rready),
    .rdata        (rdata),
    .rresp        (rresp),
    .awvalid      (awvalid),
    .awready      (awready),
    .awaddr       (awaddr),
    .wvalid       (wvalid),
    .wready       (wready),
    .wdata        (wdata),
    .bvalid       (bvalid),
    .bready       (bready),
    .bresp        (bresp),
    .regs_o       (regs_o),
    .reg_wr_pulse (reg_wr_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input bit wr);
    longint unsigned off;
    if (a < BASE_ADDR) return 2'b11;
    off = longint'(a) - longint'(BASE_ADDR);
    if (off >= NUM_REGS * 8) return 2'b11;
    if (off % 8 != 0) return 2'b10;
    if (wr && off / 8 == 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    return int'((a - BASE_ADDR) / 8);
  endfunction

  task automatic model_reset();
    model[0] = MAGIC;
    for (int i = 1; i < NUM_REGS; i++) model[i] = '0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      check($sformatf("%s_reg%0d", tag, i), regs_o[i*64 +: 64], model[i]);
    end
  endtask

  task automatic read_txn(input logic [31:0] a, input string tag);
    logic [1:0]  er;
    logic [63:0] ed;
    er = exp_resp(a, 1'b0);
    ed = (er == 2'b00) ? model[addr_idx(a)] : 64'h0;
    check({tag, "_arready"}, {63'h0, arready}, 64'h1);
    arvalid = 1'b1;
    araddr  = a;
    tick();
    arvalid = 1'b0;
    check({tag, "_rvalid"}, {63'h0, rvalid}, 64'h1);
    check({tag, "_rdata"}, rdata, ed);
    check({tag, "_rresp"}, {62'h0, rresp}, {62'h0, er});
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, "_rvalid_done"}, {63'h0, rvalid}, 64'h0);
  endtask

  // mode 0: AW and W together; 1: AW first; 2: W first. gap = idle cycles between them.
  task automatic write_txn(input logic [31:0] a, input logic [63:0] d, input int mode,
                           input int gap, input string tag);
    logic [1:0]          er;
    logic [NUM_REGS-1:0] ep;
    er = exp_resp(a, 1'b1);
    ep = '0;
    if (er == 2'b00) ep[addr_idx(a)] = 1'b1;
    awaddr = a;
    wdata  = d;
    if (mode == 0) begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else begin
      awvalid = (mode == 1);
      wvalid  = (mode == 2);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      for (int k = 0; k < gap; k++) begin
        check({tag, "_held_ready"}, {62'h0, awready, wready},
              (mode == 1) ? 64'h1 : 64'h2);
        check({tag, "_early_bvalid"}, {63'h0, bvalid}, 64'h0);
        tick();
      end
      awvalid = (mode == 2);
      wvalid  = (mode == 1);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    if (er == 2'b00) model[addr_idx(a)] = d;
    check({tag, "_bvalid"}, {63'h0, bvalid}, 64'h1);
    check({tag, "_bresp"}, {62'h0, bresp}, {62'h0, er});
    check({tag, "_pulse"}, 64'(reg_wr_pulse), 64'(ep));
    check_regs(tag);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_bvalid_done"}, {63'h0, bvalid}, 64'h0);
    check({tag, "_pulse_done"}, 64'(reg_wr_pulse), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] old_val, held_rdata;
    logic [31:0] a;

    rst = 1'b1; arvalid = 1'b0; araddr = '0; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; bready = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    check("rst_readies", {61'h0, arready, awready, wready}, 64'h7);
    check("rst_valids", {62'h0, rvalid, bvalid}, 64'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_resps", {60'h0, rresp, bresp}, 64'h0);
    check("rst_pulse", 64'(reg_wr_pulse), 64'h0);
    check_regs("rst");

    read_txn(32'h0, "rd_magic");
    read_txn(32'h8, "rd_r1");

    write_txn(32'h18, 64'hDEAD_BEEF_0000_0001, 0, 0, "wr_r3");
    read_txn(32'h18, "rd_r3");

    write_txn(32'h10, 64'd5, 2, 3, "wr_w_first");
    read_txn(32'h10, "rd_r2");

    write_txn(32'h0, 64'h1234, 0, 0, "wr_magic_err");
    read_txn(32'h0C, "rd_misalign");
    read_txn(NUM_REGS * 8, "rd_decerr");
    write_txn(32'hFFFF_FFF8, 64'hFFFF, 1, 1, "wr_decerr");

    // Randomized mix of reads and writes in every channel ordering.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8;
      else a = BASE_ADDR + 32'($urandom_range(0, NUM_REGS + 1) * 8);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 7));
      if ($urandom_range(0, 1) == 0) read_txn(a, "rnd_rd");
      else write_txn(a, {$urandom, $urandom}, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), "rnd_wr");
    end

    // Same-cycle read and write commit to register 5: the read sees the old value.
    old_val = model[5];
    arvalid = 1'b1; araddr = 32'h28;
    awvalid = 1'b1; awaddr = 32'h28; wvalid = 1'b1; wdata = 64'hA5A5_0000_5A5A_FFFF;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model[5] = 64'hA5A5_0000_5A5A_FFFF;
    check("rw_same_rdata", rdata, old_val);
    check("rw_same_valids", {62'h0, rvalid, bvalid}, 64'h3);
    check("rw_same_pulse", 64'(reg_wr_pulse), 64'h20);

    // Backpressure: responses held, competing requests must not be accepted.
    held_rdata = rdata;
    arvalid = 1'b1; araddr = 32'h8;
    awvalid = 1'b1; awaddr = 32'h38; wvalid = 1'b1; wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valids", {62'h0, rvalid, bvalid}, 64'h3);
      check("bp_readies", {61'h0, arready, awready, wready}, 64'h0);
      check("bp_rdata", rdata, held_rdata);
      check("bp_resps", {60'h0, rresp, bresp}, 64'h0);
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    check("bp_done_valids", {62'h0, rvalid, bvalid}, 64'h0);
    check_regs("bp");
    read_txn(32'h38, "rd_after_bp");

    // Reset while both response states are pending.
    arvalid = 1'b1; araddr = 32'h18;
    awvalid = 1'b1; awaddr = 32'h20; wvalid = 1'b1; wdata = 64'h77;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_valids", {62'h0, rvalid, bvalid}, 64'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("mid_rst_valids", {62'h0, rvalid, bvalid}, 64'h0);
    check("mid_rst_readies", {61'h0, arready, awready, wready}, 64'h7);
    check("mid_rst_pulse", 64'(reg_wr_pulse), 64'h0);
    check_regs("mid_rst");
    tick();
    check("post_rst_valids", {62'h0, rvalid, bvalid}, 64'h0);
    write_txn(32'h8, 64'h0123_4567_89AB_CDEF, 1, 0, "post_rst_wr");
    read_txn(32'h8, "post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
